// File: rtl/rtcdate_alarm.sv
// Calendar date peripheral on Wishbone: BCD date + day-of-week advanced by a
// pulse-per-day, with NALARM date-alarm channels (year FFFF = every year).
module rtcdate_alarm #(
   parameter int          NALARM     = 2,
   parameter logic [31:0] RESET_DATE = 32'h20000101,
   parameter logic [2:0]  RESET_DOW  = 3'd6
) (
   input  logic        i_clk,
   input  logic        i_areset_n,
   input  logic        i_ppd,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [2:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic        o_int
);

   // Bus handshake: a request is i_wb_cyc & i_wb_stb in any cycle; it is never
   // stalled and is acknowledged exactly one cycle later with the read data
   // captured at the request edge. Writes commit at that same edge.
   localparam logic [3:0] CH_MASK = 4'((32'd1 << NALARM) - 32'd1);

   logic [31:0] date_q;
   logic [2:0]  dow_q;
   logic [3:0]  pending_q;
   logic [3:0]  enable_q;
   logic [31:0] alarm_q [NALARM];

   logic        wb_req, wb_wr;
   logic        wr_date, wr_dow, wr_ctrl;
   logic [31:0] inc_date;
   logic [7:0]  mlen;
   logic        leap;
   logic [3:0]  match;
   logic [3:0]  pending_d;
   logic [31:0] rdata_d;

   function automatic logic bcd_div4(input logic [7:0] b);
      if (b[4])
         return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
      else
         return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
   endfunction

   function automatic logic [7:0] bcd_inc8(input logic [7:0] b);
      if (b[3:0] == 4'd9)
         return {b[7:4] + 4'd1, 4'd0};
      else
         return {b[7:4], b[3:0] + 4'd1};
   endfunction

   function automatic logic [15:0] bcd_inc16(input logic [15:0] y);
      logic [15:0] r;
      logic        c;
      r = y;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign wb_req  = i_wb_cyc & i_wb_stb;
   assign wb_wr   = wb_req & i_wb_we;
   assign wr_date = wb_wr && (i_wb_addr == 3'd0);
   assign wr_dow  = wb_wr && (i_wb_addr == 3'd1);
   assign wr_ctrl = wb_wr && (i_wb_addr == 3'd2);

   // Century digits decide leap only when the low two year digits are 00.
   assign leap = (date_q[23:16] == 8'h00) ? bcd_div4(date_q[31:24])
                                          : bcd_div4(date_q[23:16]);

   always_comb begin
      mlen = 8'h31;
      case (date_q[15:8])
         8'h04, 8'h06, 8'h09, 8'h11: mlen = 8'h30;
         8'h02:                      mlen = leap ? 8'h29 : 8'h28;
         default:                    mlen = 8'h31;
      endcase
   end

   always_comb begin
      inc_date = date_q;
      if (date_q[7:0] >= mlen) begin
         inc_date[7:0] = 8'h01;
         if (date_q[15:8] >= 8'h12) begin
            inc_date[15:8]  = 8'h01;
            inc_date[31:16] = bcd_inc16(date_q[31:16]);
         end else begin
            inc_date[15:8] = bcd_inc8(date_q[15:8]);
         end
      end else begin
         inc_date[7:0] = bcd_inc8(date_q[7:0]);
      end
   end

   // Alarms compare only against a date produced by an increment that lands.
   always_comb begin
      match = 4'd0;
      for (int n = 0; n < NALARM; n++) begin
         match[n] = i_ppd && !wr_date &&
                    (alarm_q[n][15:0] == inc_date[15:0]) &&
                    ((alarm_q[n][31:16] == inc_date[31:16]) ||
                     (alarm_q[n][31:16] == 16'hFFFF));
      end
      pending_d = ((pending_q & ~(wr_ctrl ? i_wb_data[3:0] : 4'd0)) | match) & CH_MASK;
   end

   always_comb begin
      rdata_d = 32'd0;
      case (i_wb_addr)
         3'd0:    rdata_d = date_q;
         3'd1:    rdata_d = {29'd0, dow_q};
         3'd2:    rdata_d = {12'd0, enable_q, 12'd0, pending_q};
         default: begin
            for (int n = 0; n < NALARM; n++) begin
               if (i_wb_addr == 3'(4 + n))
                  rdata_d = alarm_q[n];
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         date_q    <= RESET_DATE;
         dow_q     <= RESET_DOW;
         pending_q <= 4'd0;
         enable_q  <= 4'd0;
         for (int n = 0; n < NALARM; n++)
            alarm_q[n] <= 32'd0;
         o_wb_ack  <= 1'b0;
         o_wb_data <= 32'd0;
         o_int     <= 1'b0;
      end else begin
         if (wr_date)
            date_q <= i_wb_data;
         else if (i_ppd)
            date_q <= inc_date;

         if (wr_dow)
            dow_q <= i_wb_data[2:0];
         else if (i_ppd)
            dow_q <= (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;

         pending_q <= pending_d;
         if (wr_ctrl)
            enable_q <= i_wb_data[19:16] & CH_MASK;

         for (int n = 0; n < NALARM; n++) begin
            if (wb_wr && (i_wb_addr == 3'(4 + n)))
               alarm_q[n] <= i_wb_data;
         end

         o_wb_ack <= wb_req;
         if (wb_req)
            o_wb_data <= rdata_d;
         o_int <= |(pending_q & enable_q);
      end
   end

   assign o_wb_stall = 1'b0;

endmodule

// File: tb/tb_rtcdate_alarm.sv
// Directed bench for rtcdate_alarm: bus drivers push expected read data into a
// queue, an ack-driven monitor pops and compares.
module tb_rtcdate_alarm;

  logic        i_clk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        i_ppd = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [2:0]  i_wb_addr = 3'd0;
  logic [31:0] i_wb_data = 32'd0;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_int;

  rtcdate_alarm #(.NALARM(2), .RESET_DATE(32'h20000101), .RESET_DOW(3'd6)) dut (
    .i_clk(i_clk), .i_areset_n(i_areset_n), .i_ppd(i_ppd),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_int(o_int)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int ack_run = 0;
  int ack_run_max = 0;

  logic [31:0] exp_q[$];
  logic        chk_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver tasks: one strobe per call; consecutive calls give back-to-back strobes
  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string nm);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = a; i_wb_data = d;
    exp_q.push_back(exp); chk_q.push_back(chk); name_q.push_back(nm);
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, a, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic pulse();
    i_ppd = 1'b1;
    @(posedge i_clk); #1;
    i_ppd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (o_wb_ack) begin
      ack_run++;
      if (ack_run > ack_run_max) ack_run_max = ack_run;
      check("stall_at_ack", {31'd0, o_wb_stall}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        logic        c;
        string       nm;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        nm = name_q.pop_front();
        if (c) check(nm, o_wb_data, e);
      end
    end else begin
      ack_run = 0;
    end
  end

  initial begin
    #12;
    check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    check("rst_int", {31'd0, o_int}, 32'd0);
    check("rst_rdata", o_wb_data, 32'd0);
    @(negedge i_clk); i_areset_n = 1'b1;
    @(posedge i_clk); #1;

    rd(3'd0, 32'h20000101, "rst_date");
    rd(3'd1, 32'd6, "rst_dow");
    rd(3'd2, 32'd0, "rst_ctrl");
    check("rst_int_after", {31'd0, o_int}, 32'd0);

    // leap-year walk
    wr(3'd0, 32'h20240228); pulse(); rd(3'd0, 32'h20240229, "leap_2024_29");
    pulse(); rd(3'd0, 32'h20240301, "leap_2024_0301");
    rd(3'd1, 32'd1, "dow_after_two");
    wr(3'd0, 32'h19000228); pulse(); rd(3'd0, 32'h19000301, "nonleap_1900");
    wr(3'd0, 32'h20000228); pulse(); rd(3'd0, 32'h20000229, "leap_2000");
    rd(3'd1, 32'd3, "dow_3");

    // year rollover and dow wrap
    wr(3'd0, 32'h99991231); wr(3'd1, 32'd6); pulse();
    rd(3'd0, 32'h00000101, "year_wrap");
    rd(3'd1, 32'd0, "dow_wrap");

    // out-of-range written day
    wr(3'd0, 32'h20250232); pulse(); rd(3'd0, 32'h20250301, "bad_day_fix");

    // annual alarm and interrupt latency
    wr(3'd4, 32'hFFFF0101); wr(3'd2, 32'h00010000); wr(3'd0, 32'h20251231);
    pulse();
    check("int_not_yet", {31'd0, o_int}, 32'd0);
    @(posedge i_clk); #1;
    check("int_set", {31'd0, o_int}, 32'd1);
    rd(3'd0, 32'h20260101, "alarm_date");
    rd(3'd2, 32'h00010001, "alarm_pending");
    wr(3'd2, 32'h00000001); idle(2);
    check("int_cleared", {31'd0, o_int}, 32'd0);
    rd(3'd2, 32'd0, "ctrl_cleared");

    // writes never match
    wr(3'd0, 32'h20250101); rd(3'd2, 32'd0, "write_no_match");

    // date write beats same-cycle increment; dow still moves (1 -> 2 -> 3)
    i_ppd = 1'b1; wr(3'd0, 32'h20250315); i_ppd = 1'b0;
    rd(3'd0, 32'h20250315, "write_wins");
    rd(3'd1, 32'd3, "dow_still_inc");
    rd(3'd2, 32'd0, "write_wins_no_pend");

    // two consecutive pulses, alarm pending with irq disabled
    wr(3'd0, 32'h20241230);
    i_ppd = 1'b1; idle(2); i_ppd = 1'b0;
    rd(3'd0, 32'h20250101, "two_pulses");
    rd(3'd2, 32'h00000001, "pend_no_enable");
    check("int_disabled", {31'd0, o_int}, 32'd0);
    rd(3'd1, 32'd5, "dow_two_pulses");

    // unmapped addresses and unused ctrl bits
    wr(3'd6, 32'hDEADBEEF); rd(3'd6, 32'd0, "alarm2_absent");
    rd(3'd7, 32'd0, "addr7");
    rd(3'd3, 32'd0, "addr3");
    wr(3'd5, 32'h20300615); rd(3'd5, 32'h20300615, "alarm1_rw");
    wr(3'd2, 32'hFFFFFFFF); rd(3'd2, 32'h00030000, "ctrl_mask");
    idle(2);

    // back-to-back reads
    ack_run_max = 0;
    rd(3'd0, 32'h20250101, "b2b_date");
    rd(3'd1, 32'd5, "b2b_dow");
    rd(3'd2, 32'h00030000, "b2b_ctrl");
    idle(2);
    check("b2b_ack_run", ack_run_max, 32'd3);

    // reset mid-transaction: no ack, no commit
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = 3'd0; i_wb_data = 32'h12345678;
    #2 i_areset_n = 1'b0;
    #1 check("midrst_ack", {31'd0, o_wb_ack}, 32'd0);
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_areset_n = 1'b1;
    @(posedge i_clk); #1;
    rd(3'd0, 32'h20000101, "midrst_date");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge i_clk); #1;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
